// File: rtl/cell_sweep_pkg.sv
// Shared types and default constants for the cell truth-table sweep controller.
package cell_sweep_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

  localparam int N_IN_DEF   = 6;
  localparam int SETTLE_DEF = 15;
endpackage

// File: rtl/sweep_timer.sv
// Settle down-counter: loads SETTLE-1, counts down to zero and parks there.
module sweep_timer #(
  parameter int SETTLE = cell_sweep_pkg::SETTLE_DEF
) (
  input  logic CK,
  input  logic RST,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(SETTLE - 1);

  logic [W-1:0] count;

  always_ff @(posedge CK or posedge RST) begin
    if (RST)
      count <= '0;
    else if (load)
      count <= LOAD_VAL;
    else if (dec && count != '0)
      count <= count - W'(1);
  end

  assign zero = (count == '0);
endmodule

// File: rtl/cell_sweep_ctrl.sv
// Walks every input vector of a cell under test, lets it settle, samples the
// cell output against an expected truth table and records failures.
module cell_sweep_ctrl #(
  parameter int N_IN   = cell_sweep_pkg::N_IN_DEF,
  parameter int SETTLE = cell_sweep_pkg::SETTLE_DEF
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   exp_tt,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 sample_valid,
  output logic                 mismatch,
  output logic [N_IN:0]        err_cnt,
  output logic [N_IN-1:0]      first_fail
);
  import cell_sweep_pkg::*;

  localparam logic [N_IN-1:0] VEC_LAST = '1;
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

  state_t state;
  logic   accept;
  logic   tmr_load;
  logic   tmr_dec;
  logic   tmr_zero;

  assign accept   = (state == ST_IDLE || state == ST_DONE) && start && !abort;
  assign tmr_load = accept || (state == ST_SAMPLE && !abort && vec != VEC_LAST);
  assign tmr_dec  = (state == ST_SETTLE);

  sweep_timer #(.SETTLE(SETTLE)) u_timer (
    .CK   (CK),
    .RST  (RST),
    .load (tmr_load),
    .dec  (tmr_dec),
    .zero (tmr_zero)
  );

  // dut_out only reaches the error registers; it never steers the state.
  assign mismatch = sample_valid && (dut_out != exp_tt[vec]);
  assign pass     = done && (err_cnt == '0);

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state        <= ST_IDLE;
      vec          <= '0;
      err_cnt      <= '0;
      first_fail   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_valid <= 1'b0;
    end else if (abort) begin
      state        <= ST_IDLE;
      vec          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_SETTLE;
            vec        <= '0;
            err_cnt    <= '0;
            first_fail <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (tmr_zero) begin
            state        <= ST_SAMPLE;
            sample_valid <= 1'b1;
          end
        end
        ST_SAMPLE: begin
          sample_valid <= 1'b0;
          if (mismatch) begin
            err_cnt <= err_cnt + ERR_ONE;
            if (err_cnt == '0)
              first_fail <= vec;
          end
          // The last vector is kept on the pins rather than wrapping to zero.
          if (vec == VEC_LAST) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= ST_SETTLE;
            vec   <= vec + VEC_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
